// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with baud tick, TX serialiser, 16x RX deserialiser and RX FIFO
//
// Frame: start(0), DATA_BITS data LSB first, optional even parity, stop(1).
// Optional feature macro: UART_PARITY_EN adds the parity bit on TX, checks it on RX
// and exposes the sticky rx_parity_err output.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   tx_data        word to send, captured when tx_wr is accepted in idle
//   tx_wr          one-cycle transmit strobe, ignored while tx_busy
//   tx_busy        high from the cycle after an accepted write until the stop bit ends
//   uart_txd       serial output, idle high
//   uart_rxd       serial input, asynchronous to clk
//   rx_data        FIFO head (zero when empty)
//   rx_avail       FIFO not empty
//   rx_rd          pop strobe, ignored when empty
//   rx_overrun     sticky: a good frame was dropped because the FIFO was full
//   rx_frame_err   sticky: stop bit sampled low
//   rx_parity_err  sticky: parity mismatch (UART_PARITY_EN only)
//   rx_err_clr     clears all sticky flags, wins over a same-cycle set
module uart_fifo_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_busy,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_avail,
  input  logic                 rx_rd,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
  output logic                 rx_parity_err,
`endif
  input  logic                 rx_err_clr
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_t;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick;
  tx_st_t tx_st_q, tx_st_d;
  logic [3:0] tx_tc_q, tx_tc_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic txd_q, txd_d, busy_q, busy_d, tx_adv;
  rx_st_t rx_st_q, rx_st_d;
  logic [2:0] sync_q, sync_d;
  logic [3:0] rx_tc_q, rx_tc_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic rxd_s, fall, rx_adv, push, set_ferr;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic empty, full, pop, push_ok;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic tx_par_q, tx_par_d, par_bad_q, par_bad_d, perr_q, perr_d, set_perr;
`endif
  assign tick = cnt_q == CW'(DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);
  assign rxd_s = sync_q[1];
  // sync_q[2] is the previous synchronised sample, used only for start-edge detection
  assign fall = sync_q[2] & ~sync_q[1];
  assign sync_d = {sync_q[1:0], uart_rxd};
  assign tx_adv = tick && tx_tc_q == 4'd15;
  assign rx_adv = tick && rx_tc_q == 4'd15;
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tc_d = tick ? tx_tc_q + 4'd1 : tx_tc_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    txd_d = txd_q;
    busy_d = busy_q;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    case (tx_st_q)
      TX_IDLE: if (tx_wr) begin
        tx_st_d = TX_WAIT;
        tx_sh_d = tx_data;
        busy_d = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_d = ^tx_data;
`endif
      end
      // align the start bit to the free-running tick so every bit is exactly 16 ticks
      TX_WAIT: if (tick) begin
        tx_st_d = TX_START;
        tx_tc_d = '0;
        txd_d = 1'b0;
      end
      TX_START: if (tx_adv) begin
        tx_st_d = TX_DATA;
        tx_bit_d = '0;
        txd_d = tx_sh_q[0];
      end
      TX_DATA: if (tx_adv) begin
        if (tx_bit_q == LAST) begin
`ifdef UART_PARITY_EN
          tx_st_d = TX_PAR;
          txd_d = tx_par_q;
`else
          tx_st_d = TX_STOP;
          txd_d = 1'b1;
`endif
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
          tx_sh_d = tx_sh_q >> 1;
          txd_d = tx_sh_q[1];
        end
      end
      TX_PAR: if (tx_adv) begin
        tx_st_d = TX_STOP;
        txd_d = 1'b1;
      end
      TX_STOP: if (tx_adv) begin
        tx_st_d = TX_IDLE;
        busy_d = 1'b0;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_tc_d = tick ? rx_tc_q + 4'd1 : rx_tc_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    push = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
    set_perr = 1'b0;
`endif
    case (rx_st_q)
      RX_IDLE: if (fall) begin
        rx_st_d = RX_START;
        rx_tc_d = '0;
      end
      // 8th tick after the edge is mid start bit; later samples are 16 ticks apart
      RX_START: if (tick && rx_tc_q == 4'd7) begin
        rx_st_d = rxd_s ? RX_IDLE : RX_DATA;
        rx_tc_d = '0;
        rx_bit_d = '0;
      end
      RX_DATA: if (rx_adv) begin
        rx_sh_d = {rxd_s, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + BW'(1);
`ifdef UART_PARITY_EN
        if (rx_bit_q == LAST) rx_st_d = RX_PAR;
`else
        if (rx_bit_q == LAST) rx_st_d = RX_STOP;
`endif
      end
      RX_PAR: if (rx_adv) begin
        rx_st_d = RX_STOP;
`ifdef UART_PARITY_EN
        par_bad_d = rxd_s != ^rx_sh_q;
`endif
      end
      // leave at mid-stop so a start edge right after the stop bit is caught
      RX_STOP: if (rx_adv) begin
        rx_st_d = RX_IDLE;
        set_ferr = !rxd_s;
`ifdef UART_PARITY_EN
        set_perr = rxd_s && par_bad_q;
        push = rxd_s && !par_bad_q;
`else
        push = rxd_s;
`endif
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop = rx_rd && !empty;
    push_ok = push && (!full || pop);
    mem_d = mem_q;
    if (push_ok) mem_d[wp_q[AW-1:0]] = rx_sh_q;
    wp_d = push_ok ? wp_q + (AW+1)'(1) : wp_q;
    rp_d = pop ? rp_q + (AW+1)'(1) : rp_q;
    ovr_d = !rx_err_clr && (ovr_q || (push && !push_ok));
    ferr_d = !rx_err_clr && (ferr_q || set_ferr);
`ifdef UART_PARITY_EN
    perr_d = !rx_err_clr && (perr_q || set_perr);
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tx_st_q <= TX_IDLE;
      tx_tc_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      rx_st_q <= RX_IDLE;
      sync_q <= 3'b111;
      rx_tc_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
      par_bad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      tx_st_q <= tx_st_d;
      tx_tc_q <= tx_tc_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      rx_st_q <= rx_st_d;
      sync_q <= sync_d;
      rx_tc_q <= rx_tc_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
`ifdef UART_PARITY_EN
      tx_par_q <= tx_par_d;
      par_bad_q <= par_bad_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign uart_txd = txd_q;
  assign tx_busy = busy_q;
  assign rx_avail = !empty;
  assign rx_data = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign rx_overrun = ovr_q;
  assign rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: checks uart_fifo_core at DIV=27 (432 clk per bit), 8 data bits, 4-entry FIFO
module tb_uart_fifo_core;
  localparam int BITC = 432;
  typedef struct {
    int op;
    logic [7:0] d;
    logic stop;
    logic e_avail;
    logic [7:0] e_data;
    logic e_ovr;
    logic e_ferr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_wr = 1'b0;
  logic tx_busy, uart_txd, uart_rxd;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic [7:0] rx_data;
  logic rx_avail, rx_overrun, rx_frame_err;
  logic rx_rd = 1'b0;
  logic rx_err_clr = 1'b0;
`ifdef UART_PARITY_EN
  logic rx_parity_err;
  bit m_perr;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mq[$];
  bit m_ovr, m_ferr;
  vec_t tbl[12];
  logic [9:0] txexp;
  time t_wr, t_f;
  int n, r;
  bit ok, saw_low;
  assign uart_rxd = loop ? uart_txd : rxd_drv;
  always #5 clk = ~clk;
  uart_fifo_core #(.CLK_HZ(50_000_000), .BAUD(115_200), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd), .rx_data(rx_data), .rx_avail(rx_avail),
    .rx_rd(rx_rd), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
`ifdef UART_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_err_clr(rx_err_clr));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (!par_ok) begin
`ifdef UART_PARITY_EN
      m_perr = 1'b1;
`endif
    end
    else if (mq.size() < 4) mq.push_back(d);
    else m_ovr = 1'b1;
  endtask
  task automatic drive_bits(input logic [11:0] b, input int k);
    for (int i = 0; i < k; i++) begin
      rxd_drv = b[i];
      cyc(BITC);
    end
    rxd_drv = 1'b1;
    cyc(20);
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
    drive_bits({2'b00, stop, ^d, d, 1'b0}, 11);
`else
    drive_bits({3'b000, stop, d, 1'b0}, 10);
`endif
    model_frame(d, stop, 1'b1);
  endtask
`ifdef UART_PARITY_EN
  task automatic send_rx_par(input logic [7:0] d, input logic p);
    drive_bits({2'b00, 1'b1, p, d, 1'b0}, 11);
    model_frame(d, 1'b1, p == ^d);
  endtask
`endif
  task automatic pop();
    @(negedge clk) rx_rd = 1'b1;
    @(negedge clk) rx_rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask
  task automatic clr();
    @(negedge clk) rx_err_clr = 1'b1;
    @(negedge clk) rx_err_clr = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
`ifdef UART_PARITY_EN
    m_perr = 1'b0;
`endif
  endtask
  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr = 1'b1;
    t_wr = $time;
    @(negedge clk) tx_wr = 1'b0;
  endtask
  task automatic check_state(input string tag);
    chk({tag, ".avail"}, rx_avail, mq.size() != 0);
    if (mq.size() != 0) chk({tag, ".data"}, rx_data, mq[0]);
    chk({tag, ".overrun"}, rx_overrun, m_ovr);
    chk({tag, ".frame_err"}, rx_frame_err, m_ferr);
`ifdef UART_PARITY_EN
    chk({tag, ".parity_err"}, rx_parity_err, m_perr);
`endif
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{0, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{0, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3]  = '{0, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4]  = '{0, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[5]  = '{0, 8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6]  = '{0, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[7]  = '{1, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[8]  = '{1, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[9]  = '{1, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[10] = '{1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    cyc(5);
    reset = 1'b0;
    cyc(2);
    chk("rst.txd", uart_txd, 1);
    chk("rst.busy", tx_busy, 0);
    chk("rst.rx_data", rx_data, 0);
    check_state("rst");
    tx_write(8'hA5);
    chk("tx.busy_after_wr", tx_busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (uart_txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tx.start_seen", ok, 1);
    if (ok) begin
      txexp = {1'b1, 8'hA5, 1'b0};
      cyc(BITC / 2);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("tx.bit%0d", i), uart_txd, txexp[i]);
        if (i == 2) begin
          tx_data = 8'h3C;
          tx_wr = 1'b1;
          cyc(1);
          tx_wr = 1'b0;
          cyc(BITC - 1);
        end else if (i < 9) cyc(BITC);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t_f = $time;
    n = int'((t_f - t_wr) / 10) - 1;
    n_cmp++;
    if (!ok || n < 4321 || n > 4347) begin
      n_bad++;
      $display("FAIL tx.busy_len: got %0d cycles want 4321..4347", n);
    end
    saw_low = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (uart_txd === 1'b0) saw_low = 1'b1;
      @(negedge clk);
    end
    chk("tx.busy_write_ignored", saw_low, 0);
    loop = 1'b1;
    tx_write(8'h5A);
    model_frame(8'h5A, 1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("loop.done", ok, 1);
    cyc(5);
    check_state("loop");
    pop();
    check_state("loop.pop");
    loop = 1'b0;
    rxd_drv = 1'b0;
    cyc(100);
    rxd_drv = 1'b1;
    cyc(600);
    check_state("false_start");
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op == 0) send_rx(tbl[i].d, tbl[i].stop);
      else if (tbl[i].op == 1) pop();
      else clr();
      cyc(2);
      chk($sformatf("vec%0d.avail", i), rx_avail, tbl[i].e_avail);
      if (tbl[i].e_avail) chk($sformatf("vec%0d.data", i), rx_data, tbl[i].e_data);
      chk($sformatf("vec%0d.overrun", i), rx_overrun, tbl[i].e_ovr);
      chk($sformatf("vec%0d.frame_err", i), rx_frame_err, tbl[i].e_ferr);
    end
`ifdef UART_PARITY_EN
    send_rx_par(8'h07, 1'b0);
    check_state("par_bad");
    send_rx_par(8'h07, 1'b1);
    check_state("par_good");
    clr();
    pop();
    check_state("par_clr");
`endif
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) send_rx(8'($urandom), r != 0);
      else if (r < 8) pop();
      else clr();
      cyc(2);
      check_state($sformatf("rnd%0d", k));
    end
    tx_write(8'h00);
    cyc(1000);
    chk("midtx.txd_low", uart_txd, 0);
    chk("midtx.busy", tx_busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("midtx.rst_txd", uart_txd, 1);
    chk("midtx.rst_busy", tx_busy, 0);
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
`ifdef UART_PARITY_EN
    m_perr = 1'b0;
`endif
    @(negedge clk) reset = 1'b0;
    cyc(50);
    chk("post_rst.txd", uart_txd, 1);
    check_state("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
